w5300_bus_sched: RTL and testbench

Two-port scheduler for the CPLD's W5300 Ethernet-chip bus. It arbitrates between two requesters: port 0 is the Z80 I/O-window bridge, port 1 is the interrupt/status poller. It sequences each granted access as one timed chip cycle (setup, strobe, hold) on the W5300 `cs_n`/`rd_n`/`wr_n` lines, and returns read data with a one-cycle done pulse. It sits between the Z80 bus decoder in `top` and the W5300 pins.

---
 rtl/w5300_pkg.sv | 28 ++
 rtl/w5300_rr_arb.sv | 38 +++
 rtl/w5300_bus_sched.sv | 167 ++++++++++++++++
 tb/tb_w5300_bus_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 bus scheduler: state encoding,
// default geometry and timing, port identities and a counter helper.
package w5300_pkg;

    localparam int ABITS_DEF    = 10;
    localparam int DBITS_DEF    = 8;
    localparam int T_SETUP_DEF  = 1;
    localparam int T_STROBE_DEF = 3;
    localparam int T_HOLD_DEF   = 1;

    // Requester identities; the poller counts as "last granted" after reset.
    localparam logic PORT_BRIDGE = 1'b0;
    localparam logic PORT_POLLER = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Down-counter preload for a timed state that lasts t cycles.
    function automatic logic [3:0] cnt_load(input int t);
        return 4'(t - 1);
    endfunction

endpackage

// File: rtl/w5300_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational from the request
// vector and the last-granted flag; the flag advances only when the
// scheduler accepts a grant.
module w5300_rr_arb
    import w5300_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       gnt_o
);

    logic last_q;

    // Pick the sole requester, or on a tie the port not granted last.
    always_comb begin
        valid_o = |req_i;
        // NOTE: every path assigns gnt_o, so no latch is inferred.
        if (req_i == 2'b11) begin
            gnt_o = ~last_q;
        end else begin
            gnt_o = req_i[1];
        end
    end

    // Remember who was granted so the other port wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_POLLER;
        end else if (take_i) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/w5300_bus_sched.sv
// Two-port scheduler for the W5300 bus: arbitrates between the Z80
// bridge (port 0) and the status poller (port 1), then runs one timed
// setup/strobe/hold chip cycle per grant. All outputs are registered.
module w5300_bus_sched
    import w5300_pkg::*;
#(
    parameter int ABITS    = ABITS_DEF,
    parameter int DBITS    = DBITS_DEF,
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [ABITS-1:0] addr0,
    input  logic [ABITS-1:0] addr1,
    input  logic [DBITS-1:0] wdata0,
    input  logic [DBITS-1:0] wdata1,
    output logic             done0,
    output logic             done1,
    output logic [DBITS-1:0] rdata,
    output logic             busy,
    output logic [ABITS-1:0] w_a,
    output logic [DBITS-1:0] w_dout,
    output logic             w_doe,
    output logic             w_cs_n,
    output logic             w_rd_n,
    output logic             w_wr_n,
    input  logic [DBITS-1:0] w_din
);

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             id_q;
    logic             we_q;
    logic [ABITS-1:0] a_q;
    logic [DBITS-1:0] dout_q;
    logic [DBITS-1:0] rdata_q;
    logic             doe_q;
    logic             cs_n_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic             done0_q;
    logic             done1_q;
    logic             busy_q;

    logic             arb_valid;
    logic             arb_gnt;
    logic             take;
    logic             sel_we;
    logic [ABITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;

    assign take = (state_q == ST_IDLE) && arb_valid;

    w5300_rr_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({req1, req0}),
        .take_i (take),
        .valid_o(arb_valid),
        .gnt_o  (arb_gnt)
    );

    // Route the granted port's access parameters toward the latch.
    always_comb begin
        sel_we    = arb_gnt ? we1    : we0;
        sel_addr  = arb_gnt ? addr1  : addr0;
        sel_wdata = arb_gnt ? wdata1 : wdata0;
    end

    // Chip-cycle sequencer with registered pin and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            doe_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // Done pulses default low so each lasts exactly one cycle.
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= cnt_load(T_SETUP);
                        id_q    <= arb_gnt;
                        we_q    <= sel_we;
                        a_q     <= sel_addr;
                        dout_q  <= sel_wdata;
                        doe_q   <= sel_we;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= cnt_load(T_STROBE);
                        rd_n_q  <= we_q;
                        wr_n_q  <= ~we_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= cnt_load(T_HOLD);
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= w_din;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_DONE;
                        cs_n_q  <= 1'b1;
                        doe_q   <= 1'b0;
                        done0_q <= (id_q == PORT_BRIDGE);
                        done1_q <= (id_q == PORT_POLLER);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign w_a    = a_q;
    assign w_dout = dout_q;
    assign w_doe  = doe_q;
    assign w_cs_n = cs_n_q;
    assign w_rd_n = rd_n_q;
    assign w_wr_n = wr_n_q;

endmodule

// File: tb/tb_w5300_bus_sched.sv
// Bench for w5300_bus_sched: a default-timing instance and a
// (2,1,3)-timing instance share a byte-array model of the W5300.
module tb_w5300_bus_sched;

    localparam int TS     = 1;
    localparam int TST    = 3;
    localparam int TH     = 1;
    localparam int SUM    = TS + TST + TH;
    localparam int TS_P   = 2;
    localparam int TST_P  = 1;
    localparam int TH_P   = 3;
    localparam int SUM_P  = TS_P + TST_P + TH_P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 0, req1 = 0, req0_p = 0, req1_p = 0;
    logic       we0 = 0, we1 = 0;
    logic [9:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic       done0, done1, busy, w_doe, w_cs_n, w_rd_n, w_wr_n;
    logic [7:0] rdata, w_dout, w_din;
    logic [9:0] w_a;
    logic       done0_p, done1_p, busy_p, w_doe_p, w_cs_n_p, w_rd_n_p, w_wr_n_p;
    logic [7:0] rdata_p, w_dout_p, w_din_p;
    logic [9:0] w_a_p;

    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Chip model: only the default instance's writes land in memory.
    assign w_din   = mem[w_a];
    assign w_din_p = mem[w_a_p];
    always @(negedge clk) if (!w_cs_n && !w_wr_n) mem[w_a] <= w_dout;

    w5300_bus_sched dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
        .w_a(w_a), .w_dout(w_dout), .w_doe(w_doe), .w_cs_n(w_cs_n),
        .w_rd_n(w_rd_n), .w_wr_n(w_wr_n), .w_din(w_din)
    );

    w5300_bus_sched #(.T_SETUP(TS_P), .T_STROBE(TST_P), .T_HOLD(TH_P)) dut_p (
        .clk(clk), .rst(rst), .req0(req0_p), .req1(req1_p), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0_p), .done1(done1_p), .rdata(rdata_p), .busy(busy_p),
        .w_a(w_a_p), .w_dout(w_dout_p), .w_doe(w_doe_p), .w_cs_n(w_cs_n_p),
        .w_rd_n(w_rd_n_p), .w_wr_n(w_wr_n_p), .w_din(w_din_p)
    );

    typedef struct {
        logic       port;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         cs;
        int         stb;
        int         off;
        int         cs_p;
        int         stb_p;
        int         off_p;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic apply_reset();
        req0 = 0; req1 = 0; req0_p = 0; req1_p = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'($urandom);
        return 10'($urandom_range(0, 15));
    endfunction

    // One isolated access on both instances, measured pin by pin.
    task automatic run_vec(input vec_t v, input int idx);
        int cs = 0, stb = 0, wrong = 0, viol = 0, dn = 0, oth = 0, off = 0;
        int cs_p = 0, stb_p = 0, wrong_p = 0, viol_p = 0, dn_p = 0, oth_p = 0, off_p = 0;
        logic [7:0] rd = '0, rd_p = '0;
        logic mine, other;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        if (!v.we) mem[v.addr] = v.din;
        if (v.port) begin
            we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; req1 = 1; req1_p = 1;
        end else begin
            we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; req0 = 1; req0_p = 1;
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!w_cs_n) begin
                cs++;
                if (w_a !== v.addr || w_doe !== v.we || w_dout !== v.wdata) viol++;
            end
            if (v.we ? !w_wr_n : !w_rd_n) stb++;
            if (v.we ? !w_rd_n : !w_wr_n) wrong++;
            if ((!w_rd_n || !w_wr_n) && w_cs_n) viol++;
            mine  = v.port ? done1 : done0;
            other = v.port ? done0 : done1;
            if (other) oth++;
            if (mine) begin
                dn++; rd = rdata;
                if (off == 0) off = i;
                if (v.port) req1 = 0; else req0 = 0;
            end
            if (!w_cs_n_p) begin
                cs_p++;
                if (w_a_p !== v.addr || w_doe_p !== v.we || w_dout_p !== v.wdata) viol_p++;
            end
            if (v.we ? !w_wr_n_p : !w_rd_n_p) stb_p++;
            if (v.we ? !w_rd_n_p : !w_wr_n_p) wrong_p++;
            if ((!w_rd_n_p || !w_wr_n_p) && w_cs_n_p) viol_p++;
            mine  = v.port ? done1_p : done0_p;
            other = v.port ? done0_p : done1_p;
            if (other) oth_p++;
            if (mine) begin
                dn_p++; rd_p = rdata_p;
                if (off_p == 0) off_p = i;
                if (v.port) req1_p = 0; else req0_p = 0;
            end
        end
        check({tag, "_cs_low"}, cs, v.cs);
        check({tag, "_strobe_low"}, stb, v.stb);
        check({tag, "_wrong_strobe"}, wrong, 0);
        check({tag, "_pin_viol"}, viol, 0);
        check({tag, "_done_cnt"}, dn, 1);
        check({tag, "_other_done"}, oth, 0);
        check({tag, "_done_off"}, off, v.off);
        check({tag, "_rdata"}, rd, v.rd);
        check({tag, "_p_cs_low"}, cs_p, v.cs_p);
        check({tag, "_p_strobe_low"}, stb_p, v.stb_p);
        check({tag, "_p_wrong_strobe"}, wrong_p, 0);
        check({tag, "_p_pin_viol"}, viol_p, 0);
        check({tag, "_p_done_cnt"}, dn_p, 1);
        check({tag, "_p_other_done"}, oth_p, 0);
        check({tag, "_p_done_off"}, off_p, v.off_p);
        check({tag, "_p_rdata"}, rd_p, v.rd);
    endtask

    // Hold one port's request across two completions.
    task automatic held_pair(input logic port, input logic we, input logic [9:0] addr,
                             input logic [7:0] wd, input logic [7:0] want_rd, input string tag);
        int n = 0;
        int t0 = 0;
        logic d;
        @(negedge clk);
        if (port) begin we1 = we; addr1 = addr; wdata1 = wd; req1 = 1; end
        else begin we0 = we; addr0 = addr; wdata0 = wd; req0 = 1; end
        for (int c = 1; c <= 30 && n < 2; c++) begin
            @(negedge clk);
            d = port ? done1 : done0;
            if (d) begin
                check({tag, "_rdata"}, rdata, want_rd);
                if (n == 1) check({tag, "_period"}, c - t0, SUM + 2);
                t0 = c;
                n++;
            end
        end
        req0 = 0; req1 = 0;
        check({tag, "_done_cnt"}, n, 2);
    endtask

    // Random traffic against a transaction-level timing model.
    task automatic random_phase(input int cycles);
        int e = 0, g = 0;
        logic act = 0, last = 1'b1;
        logic a_id = 0, a_we = 0;
        logic [9:0] a_addr = '0;
        logic [7:0] a_wd = '0, exp_rd = '0;
        logic cs_e, stb_e, done_e;
        apply_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(posedge clk);
            e++;
            if (act && e >= g + SUM + 2) act = 0;
            if (!act && (req0 || req1)) begin
                a_id = (req0 && req1) ? !last : req1;
                last = a_id; act = 1; g = e;
                a_we   = a_id ? we1 : we0;
                a_addr = a_id ? addr1 : addr0;
                a_wd   = a_id ? wdata1 : wdata0;
            end
            if (act && !a_we && e == g + TS + TST) exp_rd = ref_mem[a_addr];
            @(negedge clk);
            cs_e   = act && (e < g + SUM);
            stb_e  = act && (e >= g + TS) && (e < g + TS + TST);
            done_e = act && (e == g + SUM);
            check("rnd_cs_n", w_cs_n, !cs_e);
            check("rnd_rd_n", w_rd_n, !(stb_e && !a_we));
            check("rnd_wr_n", w_wr_n, !(stb_e && a_we));
            check("rnd_doe", w_doe, cs_e && a_we);
            check("rnd_busy", busy, act && (e <= g + SUM));
            check("rnd_done0", done0, done_e && !a_id);
            check("rnd_done1", done1, done_e && a_id);
            check("rnd_rdata", rdata, exp_rd);
            if (cs_e) begin
                check("rnd_w_a", w_a, a_addr);
                check("rnd_w_dout", w_dout, a_wd);
            end
            if (done_e && a_we) ref_mem[a_addr] = a_wd;
            if (done0 && $urandom_range(0, 7) != 0) req0 = 0;
            if (done1 && $urandom_range(0, 7) != 0) req1 = 0;
            if (!req0 && $urandom_range(0, 3) == 0) begin
                we0 = 1'($urandom); addr0 = rand_addr(); wdata0 = 8'($urandom); req0 = 1;
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                we1 = 1'($urandom); addr1 = rand_addr(); wdata1 = 8'($urandom); req1 = 1;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int order[4];
        int when[4];
        bit seen;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

        vecs[0] = '{1'b0, 1'b1, 10'h12A, 8'hAB, 8'h00, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 10'h3FE, 8'h00, 8'h5C, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'h5C};
        vecs[2] = '{1'b0, 1'b0, 10'h001, 8'h77, 8'h00, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 10'h3FF, 8'hFF, 8'h00, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 10'h200, 8'h12, 8'hA5, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'hA5};
        vecs[5] = '{1'b0, 1'b1, 10'h055, 8'h3C, 8'h00, SUM, TST, SUM + 1, SUM_P, TST_P, SUM_P + 1, 8'hA5};

        // Reset state, sampled while reset is still asserted.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cs_n", w_cs_n, 1);
        check("rst_rd_n", w_rd_n, 1);
        check("rst_wr_n", w_wr_n, 1);
        check("rst_doe", w_doe, 0);
        check("rst_w_a", w_a, 0);
        check("rst_w_dout", w_dout, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", {done0, done1}, 0);
        check("rst_busy", busy, 0);
        check("rst_p_all", {w_cs_n_p, w_rd_n_p, w_wr_n_p, w_doe_p, busy_p, done0_p, done1_p},
              7'b1110000);
        check("rst_p_data", {w_a_p, w_dout_p, rdata_p}, 0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Contention from reset: grants alternate starting with port 0.
        apply_reset();
        mem[10'h011] = 8'h3A;
        mem[10'h022] = 8'hC5;
        we0 = 0; addr0 = 10'h011; we1 = 0; addr1 = 10'h022;
        req0 = 1; req1 = 1;
        n = 0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                order[n] = (done0 && done1) ? 2 : (done1 ? 1 : 0);
                when[n]  = c;
                check($sformatf("contend_rdata%0d", n), rdata, done1 ? 8'hC5 : 8'h3A);
                n++;
            end
        end
        req0 = 0; req1 = 0;
        check("contend_count", n, 4);
        for (int k = 0; k < n; k++) begin
            check($sformatf("contend_order%0d", k), order[k], k % 2);
            if (k == 0) check("contend_first", when[0], SUM + 1);
            else check($sformatf("contend_period%0d", k), when[k] - when[k-1], SUM + 2);
        end

        // Held requests repeat the access; writes leave rdata alone.
        repeat (3) @(negedge clk);
        held_pair(1'b0, 1'b1, 10'h010, 8'h42, 8'hC5, "hold_wr");
        check("hold_wr_mem", mem[10'h010], 8'h42);
        mem[10'h030] = 8'h99;
        repeat (3) @(negedge clk);
        held_pair(1'b1, 1'b0, 10'h030, 8'h00, 8'h99, "hold_rd");

        // Reset in the middle of a write strobe.
        repeat (3) @(negedge clk);
        we0 = 1; addr0 = 10'h0AA; wdata0 = 8'h77; req0 = 1;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (!w_wr_n) seen = 1;
        end
        check("rstmid_reached_strobe", seen, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_strobes", {w_cs_n, w_rd_n, w_wr_n}, 3'b111);
        check("rstmid_doe", w_doe, 0);
        check("rstmid_busy", busy, 0);
        req0 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0 || done1) n++;
        end
        check("rstmid_no_done", n, 0);
        mem[10'h044] = 8'h11;
        mem[10'h055] = 8'h22;
        we0 = 0; addr0 = 10'h044; we1 = 0; addr1 = 10'h055;
        req0 = 1; req1 = 1;
        n = 0;
        for (int c = 1; c <= 30 && n < 2; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                check($sformatf("rstmid_tie_port%0d", n), {done1, done0}, (n == 0) ? 2'b01 : 2'b10);
                check($sformatf("rstmid_tie_rdata%0d", n), rdata, (n == 0) ? 8'h11 : 8'h22);
                if (done0) req0 = 0;
                if (done1) req1 = 0;
                n++;
            end
        end
        req0 = 0; req1 = 0;
        check("rstmid_tie_count", n, 2);

        random_phase(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
